mem_arbiter: RTL

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_pkg.sv | 17 +
 rtl/rr_arbiter2.sv | 22 ++
 rtl/mem_arbiter.sv | 135 +++++++++++++
 3 files changed

// File: rtl/mem_pkg.sv
// Shared types and constants for the two-port memory arbiter.
// FSM state encoding, port indices and controller mode encodings.
package mem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_BUSY    = 2'd1,
        ST_RELEASE = 2'd2
    } state_e;

    localparam logic PORT_FETCH = 1'b0;
    localparam logic PORT_DATA  = 1'b1;

    localparam logic [1:0] MC_SINGLE = 2'b10;
    localparam logic [1:0] MC_MULTI  = 2'b11;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin winner selection.
// A lone requester always wins; on a tie the port not served last wins.
module rr_arbiter2
    import mem_pkg::*;
(
    input  logic [1:0] req_i,
    input  logic       last_i,
    output logic [1:0] gnt_o
);

    // pick the winner from the request pair and last-served pointer
    always_comb begin
        gnt_o = 2'b00;
        unique case (req_i)
            2'b01:   gnt_o = 2'b01;
            2'b10:   gnt_o = 2'b10;
            2'b11:   gnt_o = (last_i == PORT_DATA) ? 2'b01 : 2'b10;
            default: gnt_o = 2'b00;
        endcase
    end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates a fetch and a data port onto one memory controller.
// IDLE/BUSY/RELEASE FSM with handshake timeout and round-robin fairness.
module mem_arbiter
    import mem_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 48,
    parameter int TIMEOUT = 255
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              REQ0,
    input  logic              REQ1,
    input  logic [1:0]        CTRL0,
    input  logic [1:0]        CTRL1,
    input  logic [ADDR_W-1:0] ADDR0,
    input  logic [ADDR_W-1:0] ADDR1,
    output logic [1:0]        GNT,
    output logic [1:0]        DONE,
    output logic              ERR,
    output logic [DATA_W-1:0] RDATA,
    output logic              MC_ENABLE,
    output logic [1:0]        MC_CTRL,
    output logic [ADDR_W-1:0] MC_ADDRESS,
    input  logic              MC_HANDSHAKE,
    input  logic [DATA_W-1:0] MC_READ
);

    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    state_e            state_q, state_d;
    logic [1:0]        gnt_q, gnt_d;
    logic [1:0]        done_q, done_d;
    logic              err_q, err_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              en_q, en_d;
    logic [1:0]        ctrl_q, ctrl_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [7:0]        cnt_q, cnt_d;
    logic              last_q, last_d;
    logic [1:0]        arb_gnt;

    rr_arbiter2 u_rr (
        .req_i  ({REQ1, REQ0}),
        .last_i (last_q),
        .gnt_o  (arb_gnt)
    );

    // next-state and output logic; the RELEASE cycle also arbitrates so
    // back-to-back transactions see a single enable-low gap
    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        done_d  = 2'b00;
        err_d   = 1'b0;
        rdata_d = rdata_q;
        en_d    = en_q;
        ctrl_d  = ctrl_q;
        addr_d  = addr_q;
        cnt_d   = cnt_q;
        last_d  = last_q;
        unique case (state_q)
            ST_IDLE, ST_RELEASE: begin
                if (REQ0 || REQ1) begin
                    state_d = ST_BUSY;
                    gnt_d   = arb_gnt;
                    en_d    = 1'b1;
                    ctrl_d  = arb_gnt[1] ? CTRL1 : CTRL0;
                    addr_d  = arb_gnt[1] ? ADDR1 : ADDR0;
                    cnt_d   = 8'd0;
                end else begin
                    state_d = ST_IDLE;
                    gnt_d   = 2'b00;
                    en_d    = 1'b0;
                    ctrl_d  = 2'b00;
                    addr_d  = '0;
                end
            end
            ST_BUSY: begin
                if (MC_HANDSHAKE || cnt_q == CNT_LAST) begin
                    state_d = ST_RELEASE;
                    done_d  = gnt_q;
                    err_d   = ~MC_HANDSHAKE;
                    last_d  = gnt_q[PORT_DATA];
                    gnt_d   = 2'b00;
                    en_d    = 1'b0;
                    ctrl_d  = 2'b00;
                    addr_d  = '0;
                    if (MC_HANDSHAKE) begin
                        rdata_d = MC_READ;
                    end
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // state register with asynchronous active-low reset
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q <= ST_IDLE;
            gnt_q   <= 2'b00;
            done_q  <= 2'b00;
            err_q   <= 1'b0;
            rdata_q <= '0;
            en_q    <= 1'b0;
            ctrl_q  <= 2'b00;
            addr_q  <= '0;
            cnt_q   <= 8'd0;
            last_q  <= PORT_DATA;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            done_q  <= done_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
            en_q    <= en_d;
            ctrl_q  <= ctrl_d;
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
        end
    end

    assign GNT        = gnt_q;
    assign DONE       = done_q;
    assign ERR        = err_q;
    assign RDATA      = rdata_q;
    assign MC_ENABLE  = en_q;
    assign MC_CTRL    = ctrl_q;
    assign MC_ADDRESS = addr_q;

endmodule
